// File: rtl/m_store_packer_pkg.sv
// m_store_packer_pkg: store op encodings, queued entry layout and packing helpers
package m_store_packer_pkg;

    typedef enum logic [1:0] {
        STORE_W   = 2'b00,
        STORE_H   = 2'b01,
        STORE_B   = 2'b10,
        STORE_RSV = 2'b11
    } store_op_e;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } store_entry_t;

    function automatic logic store_ok(store_op_e op, logic [1:0] a);
        return (op == STORE_W) ? (a == 2'b00) : (op == STORE_H) ? !a[0] : (op == STORE_B);
    endfunction

    function automatic store_entry_t pack_store(store_op_e op, logic [31:0] addr, logic [31:0] data);
        store_entry_t e;
        e.waddr = addr[31:2];
        e.be    = (op == STORE_W) ? 4'hf : (op == STORE_H) ? (addr[1] ? 4'hc : 4'h3) : 4'b0001 << addr[1:0];
        e.wdata = (op == STORE_W) ? data : (op == STORE_H) ? {2{data[15:0]}} : {4{data[7:0]}};
        return e;
    endfunction

endpackage

// File: rtl/m_store_packer_if.sv
// m_store_packer_if: request, memory-write and error signals of the store packer
interface m_store_packer_if #(parameter int DEPTH = 2);
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [1:0]               in_op;
    logic [31:0]              in_addr;
    logic [31:0]              in_data;
    logic                     mem_valid;
    logic                     mem_ready;
    logic [31:0]              mem_addr;
    logic [31:0]              mem_wdata;
    logic [3:0]               mem_be;
    logic                     err_valid;
    logic [31:0]              err_addr;
    logic [$clog2(DEPTH):0]   count;

    modport slave (
        input  flush, in_valid, in_op, in_addr, in_data, mem_ready,
        output in_ready, mem_valid, mem_addr, mem_wdata, mem_be, err_valid, err_addr, count
    );

    modport master (
        output flush, in_valid, in_op, in_addr, in_data, mem_ready,
        input  in_ready, mem_valid, mem_addr, mem_wdata, mem_be, err_valid, err_addr, count
    );
endinterface

// File: rtl/m_store_fifo.sv
// m_store_fifo: in-order queue of packed stores with flush; head output is zero when empty
module m_store_fifo
    import m_store_packer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  store_entry_t           din,
    output store_entry_t           dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    store_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    // storage needs no reset: the head is masked to zero whenever the queue is empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // pointers wrap naturally at the power-of-two depth; flush empties the queue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    assign dout = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/m_store_packer.sv
// m_store_packer: narrows SW/SH/SB stores to byte lanes, rejects misaligned/reserved ops, queues toward memory
module m_store_packer
    import m_store_packer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    m_store_packer_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    store_entry_t entry;
    store_entry_t head;
    logic         ok;
    logic         accept;
    logic         push;
    logic         pop;

    // lane packing and alignment check of the incoming request
    always_comb begin
        entry = pack_store(store_op_e'(bus.in_op), bus.in_addr, bus.in_data);
        ok    = store_ok(store_op_e'(bus.in_op), bus.in_addr[1:0]);
    end

    assign bus.in_ready  = !bus.flush && (bus.count < FULL || (bus.mem_valid && bus.mem_ready));
    assign accept        = bus.in_valid && bus.in_ready;
    assign push          = accept && ok;
    assign pop           = bus.mem_valid && bus.mem_ready && !bus.flush;
    assign bus.mem_valid = bus.count != '0;
    assign bus.mem_addr  = {head.waddr, 2'b00};
    assign bus.mem_wdata = head.wdata;
    assign bus.mem_be    = head.be;

    // rejected requests still handshake; they raise a one-cycle pulse and record their address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.err_valid <= 1'b0;
            bus.err_addr  <= '0;
        end else begin
            bus.err_valid <= accept && !ok;
            if (accept && !ok) bus.err_addr <= bus.in_addr;
        end
    end

    m_store_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (bus.flush),
        .push    (push),
        .pop     (pop),
        .din     (entry),
        .dout    (head),
        .count   (bus.count)
    );
endmodule

// File: tb/tb_m_store_packer.sv
// tb_m_store_packer: directed vector table plus multi-cycle sequences for the store packer
module tb_m_store_packer;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   total = 0;
    int   bad = 0;

    m_store_packer_if #(.DEPTH(2)) bus ();

    m_store_packer #(.DEPTH(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic        ok;
        logic [31:0] eaddr;
        logic [31:0] ewdata;
        logic [3:0]  ebe;
    } vec_t;

    vec_t v [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        bus.in_valid = vld;
        bus.in_op    = op;
        bus.in_addr  = a;
        bus.in_data  = d;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        v[0]  = '{2'b10, 32'h0000_1003, 32'h1234_5678, 1'b1, 32'h0000_1000, 32'h7878_7878, 4'b1000};
        v[1]  = '{2'b10, 32'h0000_1000, 32'h0000_00A5, 1'b1, 32'h0000_1000, 32'hA5A5_A5A5, 4'b0001};
        v[2]  = '{2'b10, 32'h0000_1001, 32'h1122_3344, 1'b1, 32'h0000_1000, 32'h4444_4444, 4'b0010};
        v[3]  = '{2'b01, 32'h0000_2002, 32'hAAAA_BEEF, 1'b1, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100};
        v[4]  = '{2'b01, 32'h0000_2000, 32'h1234_CAFE, 1'b1, 32'h0000_2000, 32'hCAFE_CAFE, 4'b0011};
        v[5]  = '{2'b00, 32'h0000_2004, 32'hCAFE_BABE, 1'b1, 32'h0000_2004, 32'hCAFE_BABE, 4'b1111};
        v[6]  = '{2'b00, 32'h0000_3001, 32'h1111_1111, 1'b0, 32'h0000_3001, 32'h0, 4'b0};
        v[7]  = '{2'b00, 32'h0000_3002, 32'h2222_2222, 1'b0, 32'h0000_3002, 32'h0, 4'b0};
        v[8]  = '{2'b01, 32'h0000_3003, 32'h3333_3333, 1'b0, 32'h0000_3003, 32'h0, 4'b0};
        v[9]  = '{2'b01, 32'h0000_3001, 32'h4444_4444, 1'b0, 32'h0000_3001, 32'h0, 4'b0};
        v[10] = '{2'b11, 32'h0000_4000, 32'h5555_5555, 1'b0, 32'h0000_4000, 32'h0, 4'b0};
        v[11] = '{2'b10, 32'hFFFF_FFFE, 32'h0000_00FF, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'b0100};

        bus.flush = 1'b0;
        bus.mem_ready = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        #2 reset_n = 1'b0;
        tick();
        tick();
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'h0);
        chk("rst_err_valid", 32'(bus.err_valid), 32'd0);
        chk("rst_err_addr", bus.err_addr, 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        reset_n = 1'b1;
        tick();

        // table: one request, check head or error, then drain
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, v[i].op, v[i].addr, v[i].data);
            bus.mem_ready = 1'b0;
            tick();
            drive(1'b0, 2'b00, 32'h0, 32'h0);
            if (v[i].ok) begin
                chk($sformatf("v%0d_mem_valid", i), 32'(bus.mem_valid), 32'd1);
                chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, v[i].eaddr);
                chk($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, v[i].ewdata);
                chk($sformatf("v%0d_mem_be", i), 32'(bus.mem_be), 32'(v[i].ebe));
                chk($sformatf("v%0d_err_valid", i), 32'(bus.err_valid), 32'd0);
            end else begin
                chk($sformatf("v%0d_mem_valid", i), 32'(bus.mem_valid), 32'd0);
                chk($sformatf("v%0d_count", i), 32'(bus.count), 32'd0);
                chk($sformatf("v%0d_err_valid", i), 32'(bus.err_valid), 32'd1);
                chk($sformatf("v%0d_err_addr", i), bus.err_addr, v[i].eaddr);
            end
            bus.mem_ready = 1'b1;
            tick();
            chk($sformatf("v%0d_drain_count", i), 32'(bus.count), 32'd0);
            chk($sformatf("v%0d_pulse_end", i), 32'(bus.err_valid), 32'd0);
        end

        // SH then SW back-to-back with memory ready: order preserved
        bus.mem_ready = 1'b1;
        drive(1'b1, 2'b01, 32'h0000_2002, 32'hAAAA_BEEF);
        tick();
        chk("seq_sh_be", 32'(bus.mem_be), 32'hC);
        chk("seq_sh_wdata", bus.mem_wdata, 32'hBEEF_BEEF);
        drive(1'b1, 2'b00, 32'h0000_2004, 32'hCAFE_BABE);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("seq_sw_be", 32'(bus.mem_be), 32'hF);
        chk("seq_sw_wdata", bus.mem_wdata, 32'hCAFE_BABE);
        chk("seq_sw_addr", bus.mem_addr, 32'h0000_2004);
        chk("seq_sw_count", 32'(bus.count), 32'd1);
        tick();
        chk("seq_drained", 32'(bus.mem_valid), 32'd0);

        // back-to-back errors give back-to-back pulses
        drive(1'b1, 2'b00, 32'h0000_3001, 32'h0);
        tick();
        chk("err1_valid", 32'(bus.err_valid), 32'd1);
        chk("err1_addr", bus.err_addr, 32'h0000_3001);
        drive(1'b1, 2'b11, 32'h0000_5000, 32'h0);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("err2_valid", 32'(bus.err_valid), 32'd1);
        chk("err2_addr", bus.err_addr, 32'h0000_5000);
        tick();
        chk("err_end", 32'(bus.err_valid), 32'd0);
        chk("err_count", 32'(bus.count), 32'd0);

        // fill with memory stalled, then push/pop simultaneously while full
        bus.mem_ready = 1'b0;
        drive(1'b1, 2'b10, 32'h0000_0010, 32'h0000_0001);
        tick();
        chk("full_c1", 32'(bus.count), 32'd1);
        chk("full_rdy1", 32'(bus.in_ready), 32'd1);
        drive(1'b1, 2'b10, 32'h0000_0011, 32'h0000_0002);
        tick();
        chk("full_c2", 32'(bus.count), 32'd2);
        chk("full_rdy0", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 2'b10, 32'h0000_0012, 32'h0000_0003);
        tick();
        chk("full_held_count", 32'(bus.count), 32'd2);
        chk("full_head_be", 32'(bus.mem_be), 32'h1);
        chk("full_head_wdata", bus.mem_wdata, 32'h0101_0101);
        bus.mem_ready = 1'b1;
        #1;
        chk("full_rdy_bypass", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("pp_count", 32'(bus.count), 32'd2);
        chk("pp_head_be", 32'(bus.mem_be), 32'h2);
        chk("pp_head_wdata", bus.mem_wdata, 32'h0202_0202);
        tick();
        chk("pp_last_count", 32'(bus.count), 32'd1);
        chk("pp_last_be", 32'(bus.mem_be), 32'h4);
        chk("pp_last_wdata", bus.mem_wdata, 32'h0303_0303);
        tick();
        chk("pp_empty", 32'(bus.mem_valid), 32'd0);

        // flush with a same-cycle (bad) request: nothing taken, no error
        bus.mem_ready = 1'b0;
        drive(1'b1, 2'b10, 32'h0000_0020, 32'h0000_0004);
        tick();
        tick();
        chk("fl_pre_count", 32'(bus.count), 32'd2);
        bus.flush = 1'b1;
        drive(1'b1, 2'b11, 32'h0000_0030, 32'h0);
        #1;
        chk("fl_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        bus.flush = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("fl_count", 32'(bus.count), 32'd0);
        chk("fl_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("fl_err_valid", 32'(bus.err_valid), 32'd0);
        chk("fl_mem_addr", bus.mem_addr, 32'h0);

        // async reset mid-stream clears outputs before the next edge
        drive(1'b1, 2'b00, 32'h0000_0040, 32'h1234_5678);
        tick();
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("ar_pre_count", 32'(bus.count), 32'd2);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_count", 32'(bus.count), 32'd0);
        chk("ar_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("ar_mem_addr", bus.mem_addr, 32'h0);
        chk("ar_mem_wdata", bus.mem_wdata, 32'h0);
        chk("ar_mem_be", 32'(bus.mem_be), 32'h0);
        chk("ar_err_addr", bus.err_addr, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("ar_in_ready", 32'(bus.in_ready), 32'd1);
        chk("ar_post_count", 32'(bus.count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
